// File: rtl/hazard_pkg.sv
// Shared types and widths for the pipeline hazard/control unit.
package hazard_pkg;
   localparam int unsigned PC_W     = 8;
   localparam int unsigned REG_W    = 5;
   localparam int unsigned INST_W   = 32;
   localparam int unsigned MC_CNT_W = 4;

   localparam logic [INST_W-1:0] NOP_INST = 32'h00000013;

   typedef enum logic {
      RUN     = 1'b0,
      MC_WAIT = 1'b1
   } state_e;
endpackage

// File: rtl/hazard_sat_counter.sv
// Increment-enable counter that sticks at all-ones instead of wrapping.
module sat_counter
   import hazard_pkg::*;
#(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc_i,
   output logic [CNT_W-1:0] count_o
);

   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (inc_i && (count_q != {CNT_W{1'b1}})) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) count_q <= '0;
      else     count_q <= count_d;
   end

   assign count_o = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush control for the 5-stage core: load-use, redirects and
// fixed-latency multi-cycle EX ops, plus saturating perf counters.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int unsigned MC_LATENCY = 4,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [REG_W-1:0] id_rs1,
   input  logic [REG_W-1:0] id_rs2,
   input  logic             id_uses_rs1,
   input  logic             id_uses_rs2,
   input  logic [REG_W-1:0] ex_rd,
   input  logic             ex_mem_read,
   input  logic             ex_branch_taken,
   input  logic             ex_jump,
   input  logic             mc_start,
   output logic             pc_write,
   output logic             pc_sel,
   output logic             if_id_stall,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             ex_stall,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_events
);

   state_e              state_q, state_d;
   logic [MC_CNT_W-1:0] mc_cnt_q, mc_cnt_d;
   logic                redirect, load_use, flush_inc;

   assign redirect = ex_branch_taken | ex_jump;
   assign load_use = ex_mem_read && (ex_rd != '0) &&
                     ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                      (id_uses_rs2 && (id_rs2 == ex_rd)));

   // Controls act at the same edge as the registers they drive, so they are combinational.
   always_comb begin
      pc_write    = 1'b1;
      pc_sel      = 1'b0;
      if_id_stall = 1'b0;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
      ex_stall    = 1'b0;
      flush_inc   = 1'b0;
      state_d     = state_q;
      mc_cnt_d    = mc_cnt_q;

      if (rst) begin
         pc_write    = 1'b0;
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
      end else begin
         case (state_q)
            RUN: begin
               if (redirect) begin
                  pc_sel      = 1'b1;
                  if_id_flush = 1'b1;
                  id_ex_flush = 1'b1;
                  flush_inc   = 1'b1;
               end else if (mc_start) begin
                  pc_write    = 1'b0;
                  if_id_stall = 1'b1;
                  ex_stall    = 1'b1;
                  state_d     = MC_WAIT;
                  mc_cnt_d    = MC_CNT_W'(MC_LATENCY - 2);
               end else if (load_use) begin
                  pc_write    = 1'b0;
                  if_id_stall = 1'b1;
                  id_ex_flush = 1'b1;
               end
            end
            MC_WAIT: begin
               pc_write    = 1'b0;
               if_id_stall = 1'b1;
               ex_stall    = 1'b1;
               if (mc_cnt_q != '0) mc_cnt_d = mc_cnt_q - MC_CNT_W'(1);
               else                state_d  = RUN;
            end
            default: state_d = RUN;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= RUN;
         mc_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         mc_cnt_q <= mc_cnt_d;
      end
   end

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk     (clk),
      .rst     (rst),
      .inc_i   (if_id_stall),
      .count_o (stall_cycles)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk     (clk),
      .rst     (rst),
      .inc_i   (flush_inc),
      .count_o (flush_events)
   );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: vector table, corner sequences and random traffic
// against a cycle-budget reference model, on two parameterisations.
module tb_hazard_ctrl;
   import hazard_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] id_rs1, id_rs2, ex_rd;
   logic       id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken, ex_jump, mc_start;

   logic [1:0]  pc_write, pc_sel, if_id_stall, if_id_flush, id_ex_flush, ex_stall;
   logic [15:0] stall_a, flush_a;
   logic [3:0]  stall_b, flush_b;

   int n_chk  = 0;
   int n_pass = 0;

   // Reference state: remaining stall cycles of an in-flight multi-cycle op, and counters.
   int lat [2]  = '{4, 2};
   int cmax [2] = '{65535, 15};
   int mc_left [2];
   int m_stall [2];
   int m_flush [2];

   always #5 clk = ~clk;

   hazard_ctrl #(.MC_LATENCY(4), .CNT_W(16)) dut_a (
      .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
      .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken), .ex_jump(ex_jump),
      .mc_start(mc_start), .pc_write(pc_write[0]), .pc_sel(pc_sel[0]),
      .if_id_stall(if_id_stall[0]), .if_id_flush(if_id_flush[0]),
      .id_ex_flush(id_ex_flush[0]), .ex_stall(ex_stall[0]),
      .stall_cycles(stall_a), .flush_events(flush_a));

   hazard_ctrl #(.MC_LATENCY(2), .CNT_W(4)) dut_b (
      .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
      .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken), .ex_jump(ex_jump),
      .mc_start(mc_start), .pc_write(pc_write[1]), .pc_sel(pc_sel[1]),
      .if_id_stall(if_id_stall[1]), .if_id_flush(if_id_flush[1]),
      .id_ex_flush(id_ex_flush[1]), .ex_stall(ex_stall[1]),
      .stall_cycles(stall_b), .flush_events(flush_b));

   typedef struct {
      logic [4:0] rs1, rs2, rd;
      logic       u1, u2, mr, bt, jp;
      logic [5:0] exp;   // {pc_write, pc_sel, if_id_stall, if_id_flush, id_ex_flush, ex_stall}
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else n_pass++;
   endtask

   function automatic logic [5:0] dut_ctl(input int k);
      return {pc_write[k], pc_sel[k], if_id_stall[k], if_id_flush[k], id_ex_flush[k], ex_stall[k]};
   endfunction

   function automatic logic [5:0] model_ctl(input int k);
      logic redir, lu;
      redir = ex_branch_taken | ex_jump;
      lu    = ex_mem_read && ex_rd != 0 &&
              ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
      if (rst)              return 6'b000110;
      if (mc_left[k] > 0)   return 6'b001001;
      if (redir)            return 6'b110110;
      if (mc_start)         return 6'b001001;
      if (lu)               return 6'b001010;
      return 6'b100000;
   endfunction

   function automatic void model_reset();
      for (int k = 0; k < 2; k++) begin
         mc_left[k] = 0; m_stall[k] = 0; m_flush[k] = 0;
      end
   endfunction

   // Advance the model by one clock edge using the inputs held across it.
   function automatic void model_edge();
      logic [5:0] c;
      logic       redir;
      if (rst) begin
         model_reset();
         return;
      end
      redir = ex_branch_taken | ex_jump;
      for (int k = 0; k < 2; k++) begin
         c = model_ctl(k);
         if (c[3] && m_stall[k] < cmax[k]) m_stall[k]++;
         if (mc_left[k] == 0 && redir && m_flush[k] < cmax[k]) m_flush[k]++;
         if (mc_left[k] > 0)          mc_left[k]--;
         else if (!redir && mc_start) mc_left[k] = lat[k] - 1;
      end
   endfunction

   task automatic check_counters();
      chk("stall_cycles_a", 32'(stall_a), 32'(m_stall[0]));
      chk("flush_events_a", 32'(flush_a), 32'(m_flush[0]));
      chk("stall_cycles_b", 32'(stall_b), 32'(m_stall[1]));
      chk("flush_events_b", 32'(flush_b), 32'(m_flush[1]));
   endtask

   // Called just after a negedge with inputs applied; returns at the next negedge.
   task automatic step(input string name, input logic [5:0] exp_a, input bit use_exp);
      #1;
      chk({name, "_ctl_a"}, 32'(dut_ctl(0)), 32'(model_ctl(0)));
      chk({name, "_ctl_b"}, 32'(dut_ctl(1)), 32'(model_ctl(1)));
      if (use_exp) chk({name, "_tbl"}, 32'(dut_ctl(0)), 32'(exp_a));
      @(posedge clk);
      model_edge();
      #1;
      check_counters();
      @(negedge clk);
   endtask

   task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                         input logic u2, input logic [4:0] rd, input logic mr,
                         input logic bt, input logic jp, input logic mc);
      id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
      ex_rd = rd; ex_mem_read = mr; ex_branch_taken = bt; ex_jump = jp; mc_start = mc;
   endtask

   vec_t tbl [9];

   initial begin
      tbl[0] = '{rs1:0, rs2:0, rd:0, u1:0, u2:0, mr:0, bt:0, jp:0, exp:6'b100000};
      tbl[1] = '{rs1:5, rs2:0, rd:5, u1:1, u2:0, mr:1, bt:0, jp:0, exp:6'b001010};
      tbl[2] = '{rs1:0, rs2:0, rd:0, u1:1, u2:0, mr:1, bt:0, jp:0, exp:6'b100000};
      tbl[3] = '{rs1:0, rs2:7, rd:7, u1:0, u2:0, mr:1, bt:0, jp:0, exp:6'b100000};
      tbl[4] = '{rs1:0, rs2:7, rd:7, u1:0, u2:1, mr:1, bt:0, jp:0, exp:6'b001010};
      tbl[5] = '{rs1:3, rs2:0, rd:4, u1:1, u2:0, mr:1, bt:0, jp:0, exp:6'b100000};
      tbl[6] = '{rs1:4, rs2:0, rd:4, u1:1, u2:0, mr:0, bt:0, jp:0, exp:6'b100000};
      tbl[7] = '{rs1:5, rs2:0, rd:5, u1:1, u2:0, mr:1, bt:1, jp:0, exp:6'b110110};
      tbl[8] = '{rs1:0, rs2:0, rd:0, u1:0, u2:0, mr:0, bt:0, jp:1, exp:6'b110110};

      rst = 1'b1;
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      model_reset();
      #2;
      chk("reset_ctl_a", 32'(dut_ctl(0)), 32'(6'b000110));
      chk("reset_ctl_b", 32'(dut_ctl(1)), 32'(6'b000110));
      check_counters();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      foreach (tbl[i]) begin
         set_in(tbl[i].rs1, tbl[i].rs2, tbl[i].u1, tbl[i].u2, tbl[i].rd,
                tbl[i].mr, tbl[i].bt, tbl[i].jp, 1'b0);
         step($sformatf("vec%0d", i), tbl[i].exp, 1'b1);
      end
      chk("tbl_stall_total", 32'(stall_a), 32'd2);
      chk("tbl_flush_total", 32'(flush_a), 32'd2);

      // Multi-cycle op: redirect during the occupancy window must be ignored.
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
      step("mc_c1", 6'b001001, 1'b1);
      for (int c = 2; c <= 4; c++) begin
         set_in(0, 0, 0, 0, 0, 0, 1, 0, 0);
         step($sformatf("mc_c%0d", c), 6'b001001, 1'b1);
      end
      step("mc_c5", 6'b110110, 1'b1);
      chk("mc_stall_total", 32'(stall_a), 32'd6);
      chk("mc_flush_total", 32'(flush_a), 32'd3);

      // Reset asserted off-edge in the second occupancy cycle.
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
      step("rmid_c1", 6'b001001, 1'b1);
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      #2 rst = 1'b1;
      #1;
      chk("rmid_async_a", 32'(dut_ctl(0)), 32'(6'b000110));
      chk("rmid_async_b", 32'(dut_ctl(1)), 32'(6'b000110));
      model_reset();
      check_counters();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      rst = 1'b0;
      step("rmid_after", 6'b100000, 1'b1);

      // Held load-use: the 4-bit counter saturates, the 16-bit one keeps counting.
      set_in(5, 0, 1, 0, 5, 1, 0, 0, 0);
      for (int c = 0; c < 20; c++) step("sat", 6'b001010, 1'b1);
      chk("sat_stall_b", 32'(stall_b), 32'd15);
      chk("sat_stall_a", 32'(stall_a), 32'd20);

      for (int c = 0; c < 400; c++) begin
         set_in(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'($urandom),
                1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom),
                $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
                $urandom_range(0, 5) == 0);
         rst = ($urandom_range(0, 59) == 0);
         step("rand", 6'b000000, 1'b0);
      end
      rst = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
